// File: rtl/nmcu_pkg.sv
`default_nettype none
// ============================================================================
// Module : nmcu_pkg
// Brief  : Shared NMCU types and constants, including the memory-arbiter tag.
// Rev    : 1.0
// ============================================================================
package nmcu_pkg;

    localparam int DATA_WIDTH      = 32;
    localparam int ADDR_WIDTH      = 16;
    localparam int MEM_LATENCY     = 3;
    localparam int MEM_ARB_NUM_REQ = 4;
    localparam int ID_W            = 3;
    localparam int ARB_PERF_CNT_W  = 32;

    typedef struct packed {
        logic                  valid;
        logic                  write_en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } mem_req_t;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] rdata;
    } mem_resp_t;

    typedef struct packed {
        logic            issued;
        logic            is_write;
        logic [ID_W-1:0] id;
    } mem_arb_tag_t;

endpackage
`default_nettype wire

// File: rtl/nmcu_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : nmcu_rr_arbiter
// Brief  : Combinational round-robin pick over an eligibility mask + rr_ptr.
// Rev    : 1.0
// ============================================================================
module nmcu_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] eligible_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               grant_valid_o,
    output logic [PTR_W-1:0]   grant_idx_o
);

    localparam logic [PTR_W:0] N_EXT = (PTR_W + 1)'(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W:0]   cand;
    logic [PTR_W:0]   nxt;
    logic             found;

    // Walk from rr_ptr, wrapping modulo NUM_REQ, and take the first eligible index
    always_comb begin
        found       = 1'b0;
        grant_idx_o = '0;
        cand        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (PTR_W + 1)'(off);
            if (cand >= N_EXT) begin
                cand = cand - N_EXT;
            end
            if (!found && eligible_i[cand[PTR_W-1:0]]) begin
                found       = 1'b1;
                grant_idx_o = cand[PTR_W-1:0];
            end
        end
    end

    assign grant_valid_o = found;
    assign grant_o       = found ? (NUM_REQ'(1) << grant_idx_o) : '0;

    always_comb begin
        nxt = {1'b0, grant_idx_o} + (PTR_W + 1)'(1);
        if (nxt >= N_EXT) begin
            nxt = '0;
        end
        rr_ptr_d = found ? nxt[PTR_W-1:0] : rr_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nmcu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : nmcu_mem_arbiter
// Brief  : Round-robin memory arbiter with fixed-latency shadow-tag response
//          routing. Define NMCU_MEM_ARB_PERF_EN to build the perf counters.
// Rev    : 1.0
// ============================================================================
module nmcu_mem_arbiter #(
    parameter int NUM_REQ    = nmcu_pkg::MEM_ARB_NUM_REQ,
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = nmcu_pkg::ADDR_WIDTH,
    parameter int LATENCY    = nmcu_pkg::MEM_LATENCY
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic [NUM_REQ-1:0]                         req_valid_i,
    output logic [NUM_REQ-1:0]                         req_ready_o,
    input  logic [NUM_REQ-1:0]                         req_write_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]              req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]              req_wdata_i,
    output logic [NUM_REQ-1:0]                         resp_valid_o,
    output logic [DATA_WIDTH-1:0]                      resp_rdata_o,
    output logic                                       resp_is_write_o,
    output nmcu_pkg::mem_req_t                         mem_req_o,
    input  nmcu_pkg::mem_resp_t                        mem_resp_i,
    output logic                                       err_o,
    output logic [NUM_REQ*nmcu_pkg::ARB_PERF_CNT_W-1:0] perf_grant_cnt_o,
    output logic [nmcu_pkg::ARB_PERF_CNT_W-1:0]        perf_stall_cnt_o
);

    import nmcu_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic               rd_blk;

    mem_arb_tag_t tag_q [LATENCY+1];
    mem_arb_tag_t tag_d;

    logic            wr_exp, rd_exp, exp_any, hit;
    logic [ID_W-1:0] exp_id;
    logic            err_q, err_d;

    // A write issued now would ack in the same cycle as the read issued LATENCY cycles ago
    assign rd_blk   = tag_q[LATENCY-1].issued & ~tag_q[LATENCY-1].is_write;
    assign eligible = req_valid_i & ~(req_write_i & {NUM_REQ{rd_blk}});

    nmcu_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .clk           (clk),
        .rst_n         (rst_n),
        .eligible_i    (eligible),
        .grant_o       (grant),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    assign req_ready_o = grant;

    always_comb begin
        mem_req_o = '0;
        if (grant_valid) begin
            mem_req_o.valid    = 1'b1;
            mem_req_o.write_en = req_write_i[grant_idx];
            mem_req_o.addr     = req_addr_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            mem_req_o.wdata    = req_wdata_i[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        tag_d          = '0;
        tag_d.issued   = grant_valid;
        tag_d.is_write = grant_valid & req_write_i[grant_idx];
        tag_d.id       = grant_valid ? ID_W'(grant_idx) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_d;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    // Write acks surface at stage 0, read data at stage LATENCY; never both at once
    assign wr_exp  = tag_q[0].issued & tag_q[0].is_write;
    assign rd_exp  = tag_q[LATENCY].issued & ~tag_q[LATENCY].is_write;
    assign exp_any = wr_exp | rd_exp;
    assign exp_id  = wr_exp ? tag_q[0].id : tag_q[LATENCY].id;
    assign hit     = mem_resp_i.valid & exp_any;

    assign resp_valid_o    = hit ? (NUM_REQ'(1) << exp_id) : '0;
    assign resp_is_write_o = hit & wr_exp;
    assign resp_rdata_o    = (hit & ~wr_exp) ? mem_resp_i.rdata : '0;

    assign err_d = err_q | (mem_resp_i.valid ^ exp_any);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;

`ifdef NMCU_MEM_ARB_PERF_EN
    logic [ARB_PERF_CNT_W-1:0] stall_q;

    generate
        for (genvar g = 0; g < NUM_REQ; g++) begin : g_grant_cnt
            logic [ARB_PERF_CNT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (grant[g] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + ARB_PERF_CNT_W'(1);
                end
            end
            assign perf_grant_cnt_o[g*ARB_PERF_CNT_W +: ARB_PERF_CNT_W] = cnt_q;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if ((|req_valid_i) && !grant_valid && (stall_q != '1)) begin
            stall_q <= stall_q + ARB_PERF_CNT_W'(1);
        end
    end

    assign perf_stall_cnt_o = stall_q;
`else
    assign perf_grant_cnt_o = '0;
    assign perf_stall_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nmcu_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_nmcu_mem_arbiter
// Brief  : Randomized bench for nmcu_mem_arbiter with a response-slot model.
// Rev    : 1.0
// ============================================================================
module tb_nmcu_mem_arbiter;

    import nmcu_pkg::*;

    localparam int N     = 4;
    localparam int L     = 3;
    localparam int DW    = DATA_WIDTH;
    localparam int AW    = ADDR_WIDTH;
    localparam int CW    = ARB_PERF_CNT_W;
    localparam int SLOTS = 16;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid, req_write, req_ready, resp_valid;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     resp_rdata;
    logic              resp_is_write;
    mem_req_t          mem_req;
    mem_resp_t         mem_resp;
    logic              err;
    logic [N*CW-1:0]   perf_grant;
    logic [CW-1:0]     perf_stall;
    logic              inj;

    int n_chk  = 0;
    int n_fail = 0;

    nmcu_mem_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LATENCY    (L)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid_i      (req_valid),
        .req_ready_o      (req_ready),
        .req_write_i      (req_write),
        .req_addr_i       (req_addr),
        .req_wdata_i      (req_wdata),
        .resp_valid_o     (resp_valid),
        .resp_rdata_o     (resp_rdata),
        .resp_is_write_o  (resp_is_write),
        .mem_req_o        (mem_req),
        .mem_resp_i       (mem_resp),
        .err_o            (err),
        .perf_grant_cnt_o (perf_grant),
        .perf_stall_cnt_o (perf_stall)
    );

    always #5 clk = ~clk;

    // Fixed-latency memory: write ack one cycle after issue, read data LATENCY+1 after
    logic [DW-1:0] mem  [256];
    logic          rd_v [L+1];
    logic [DW-1:0] rd_d [L+1];
    logic          wack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= DW'(i + 'h100);
            for (int k = 0; k <= L; k++) begin
                rd_v[k] <= 1'b0;
                rd_d[k] <= '0;
            end
            wack <= 1'b0;
        end else begin
            wack <= mem_req.valid & mem_req.write_en;
            if (mem_req.valid && mem_req.write_en) mem[mem_req.addr[7:0]] <= mem_req.wdata;
            rd_v[0] <= mem_req.valid & ~mem_req.write_en;
            rd_d[0] <= mem[mem_req.addr[7:0]];
            for (int k = 1; k <= L; k++) begin
                rd_v[k] <= rd_v[k-1];
                rd_d[k] <= rd_d[k-1];
            end
        end
    end

    always_comb begin
        mem_resp.valid = wack | rd_v[L] | inj;
        mem_resp.rdata = rd_v[L] ? rd_d[L] : '0;
    end

    // Reference model: a calendar of expected responses indexed by cycle
    int            ptr;
    int            cyc;
    bit            err_exp;
    bit            ev  [SLOTS];
    int            eid [SLOTS];
    bit            ew  [SLOTS];
    logic [DW-1:0] ed  [SLOTS];
    logic [DW-1:0] ref_mem [256];
    longint        gcnt [N];
    longint        scnt;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        ptr = 0; cyc = 0; err_exp = 1'b0; scnt = 0;
        for (int i = 0; i < N; i++) gcnt[i] = 0;
        for (int s = 0; s < SLOTS; s++) ev[s] = 1'b0;
        for (int a = 0; a < 256; a++) ref_mem[a] = DW'(a + 'h100);
    endtask

    task automatic idle_inputs();
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; inj = 1'b0;
    endtask

    task automatic set_req(input int i, input bit wr, input int addr, input logic [DW-1:0] d);
        req_valid[i]           = 1'b1;
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = AW'(addr);
        req_wdata[i*DW +: DW]  = d;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready",      req_ready,     '0);
        chk("rst_resp_valid", resp_valid,    '0);
        chk("rst_rdata",      resp_rdata,    '0);
        chk("rst_is_write",   resp_is_write, '0);
        chk("rst_mem_req",    mem_req,       '0);
        chk("rst_err",        err,           '0);
        chk("rst_perf_grant", perf_grant,    '0);
        chk("rst_perf_stall", perf_stall,    '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic step();
        bit            el [N];
        logic [N-1:0]  g, rv;
        int            gi, sn, s1, sr;
        bit            found;
        mem_req_t      mr;
        logic [DW-1:0] rd;
        logic [AW-1:0] a;
        @(negedge clk);
        sn = cyc % SLOTS;
        s1 = (cyc + 1) % SLOTS;
        // A write may only go if its ack slot next cycle is free
        for (int i = 0; i < N; i++) el[i] = req_valid[i] && !(req_write[i] && ev[s1]);
        found = 1'b0; gi = 0;
        for (int off = 0; off < N; off++) begin
            if (!found && el[(ptr + off) % N]) begin
                found = 1'b1;
                gi    = (ptr + off) % N;
            end
        end
        g  = found ? (N'(1) << gi) : '0;
        mr = '0;
        if (found) begin
            mr.valid    = 1'b1;
            mr.write_en = req_write[gi];
            mr.addr     = req_addr[gi*AW +: AW];
            mr.wdata    = req_wdata[gi*DW +: DW];
        end
        rv = ev[sn] ? (N'(1) << eid[sn]) : '0;
        rd = (ev[sn] && !ew[sn]) ? ed[sn] : '0;
        chk("grant",         req_ready,     g);
        chk("mem_req",       mem_req,       mr);
        chk("resp_valid",    resp_valid,    rv);
        chk("resp_rdata",    resp_rdata,    rd);
        chk("resp_is_write", resp_is_write, ev[sn] && ew[sn]);
        chk("err",           err,           err_exp);
`ifdef NMCU_MEM_ARB_PERF_EN
        for (int i = 0; i < N; i++) chk("perf_grant", perf_grant[i*CW +: CW], CW'(gcnt[i]));
        chk("perf_stall", perf_stall, CW'(scnt));
`else
        chk("perf_grant_off", perf_grant, '0);
        chk("perf_stall_off", perf_stall, '0);
`endif
        if (inj && !ev[sn]) err_exp = 1'b1;
        ev[sn] = 1'b0;
        if (found) begin
            a = req_addr[gi*AW +: AW];
            if (req_write[gi]) begin
                ev[s1] = 1'b1; eid[s1] = gi; ew[s1] = 1'b1; ed[s1] = '0;
                ref_mem[a[7:0]] = req_wdata[gi*DW +: DW];
            end else begin
                sr = (cyc + L + 1) % SLOTS;
                ev[sr] = 1'b1; eid[sr] = gi; ew[sr] = 1'b0; ed[sr] = ref_mem[a[7:0]];
            end
            ptr = (gi + 1) % N;
            gcnt[gi]++;
        end else if (|req_valid) begin
            scnt++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        model_reset();
        do_reset();

        // Single read: req0 reads addr 5, data 0x105 four cycles later
        set_req(0, 1'b0, 5, '0);
        step();
        idle_inputs();
        repeat (6) step();

        // Fairness: all four read for eight cycles
        do_reset();
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < N; i++) set_req(i, 1'b0, int'($urandom_range(0, 255)), '0);
            step();
        end
        idle_inputs();
        repeat (6) step();

        // Write blocking: read at 0, write of 0xAA to addr 7 held from cycle 3
        do_reset();
        set_req(1, 1'b0, 9, '0);
        step();
        idle_inputs();
        repeat (2) step();
        set_req(2, 1'b1, 7, DW'('hAA));
        repeat (2) step();
        idle_inputs();
        step();
        set_req(0, 1'b0, 7, '0);
        step();
        idle_inputs();
        repeat (6) step();

        // Reset mid-operation: read at cycle 0, reset at cycle 2
        do_reset();
        set_req(0, 1'b0, 3, '0);
        step();
        idle_inputs();
        step();
        do_reset();
        repeat (6) step();

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle_inputs();
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 99) < 60) begin
                    set_req(i, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 255)), DW'($urandom));
                end else begin
                    req_write[i] = 1'($urandom_range(0, 1));
                end
            end
            step();
        end
        idle_inputs();
        repeat (L + 3) step();

        // Error injection: unsolicited response with an empty pipe
        inj = 1'b1;
        step();
        inj = 1'b0;
        repeat (4) step();
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
